age_port_buffer: RTL and testbench
==================================

# age_port_buffer

Per-input-port flit buffer that sits directly upstream of the two-input age arbiter tree in the fan-in stage. It queues incoming flits with their `TIME_WIDTH injection timestamps. It presents the head flit's timestamp, port index and valid flag to the arbiter leaf, and dequeues the head when the downstream arbitration result names this port. One instance per router input port; the `en`/`val`/`index` outputs wire straight into an `arb` leaf.

## Interface
- DEPTH, 4: FIFO entries; power of two, ≥2.
- DATA_WIDTH, 32: flit payload width.
- WIDTH_INDEX, 3: port index width; matches the arbiter tree.
- PORT_ID, 0: constant index this buffer reports; must be < 2^WIDTH_INDEX.
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  upstream offers a flit this cycle.
- in_time  input  `TIME_WIDTH  injection timestamp of the offered flit; smaller means older.
- in_data  input  DATA_WIDTH  offered payload.
- in_ready  output  1  buffer can accept a flit this cycle.
- en_out  output  1  head valid; drives arbiter `en_x`.
- val_out  output  `TIME_WIDTH  head timestamp; drives arbiter `val_in_x`.
- index_out  output  WIDTH_INDEX  always PORT_ID; drives arbiter `index_in_x`.
- data_out  output  DATA_WIDTH  head payload to the crossbar.
- win_valid  input  1  arbitration result is valid this cycle.
- win_index  input  WIDTH_INDEX  winning port index from the arbiter tree root.
- count  output  clog2(DEPTH)+1  current occupancy.
- overflow  output  1  sticky flag: a push was attempted while full.

## Operation
- Storage: circular buffer of DEPTH entries of {time, data}. Read and write pointers are clog2(DEPTH) bits and wrap naturally. Occupancy is held in a separate counter.
- in_ready = (count < DEPTH). It is derived only from registered state and never from a same-cycle pop.
- push = in_valid & in_ready. The entry is written at the write pointer and the write pointer increments.
- pop = win_valid & en_out & (win_index == PORT_ID). The read pointer increments. A grant received while empty is ignored.
- count update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on simultaneous push and pop, which is legal at any non-empty occupancy including full−1.
  - A full buffer with a pop does not accept a push in the same cycle, because in_ready is 0.
- en_out = (count != 0).
- When en_out=1, val_out and data_out reflect the entry at the read pointer.
- When empty, val_out and data_out are forced to 0. This keeps the arbiter input deterministic; the arbiter masks on en regardless.
- overflow:
  - Set to 1 when in_valid & !in_ready. The offered flit is dropped and no state changes.
  - Stays at 1 until reset.
- Timestamps are stored and forwarded unmodified. No arithmetic or aging is applied; wrap of `TIME_WIDTH is the arbiter's concern.
- FIFO order is strict. The head is always the oldest-enqueued entry, not the smallest timestamp.
- Reset:
  - Pointers, count and overflow are cleared to 0.
  - Outputs after reset: en_out=0, val_out=0, data_out=0, count=0, overflow=0, in_ready=1, index_out=PORT_ID.
  - Storage contents need not be cleared.
  - A reset asserted mid-operation discards all queued flits in that cycle. Any push or pop coinciding with reset is ignored.

## Timing
- Push-to-visible latency is 1 cycle. A flit pushed at edge N appears as head (en_out=1) after edge N if the buffer was empty. There is no combinational bypass from in_* to the outputs.
- Pop takes effect at the edge. The next entry, or empty, is presented after that edge. This gives back-to-back pops at one per cycle.
- The grant path win_valid/win_index → pop is combinational into the pointer update, with no extra register stage. The arbiter tree plus this compare must close in one cycle.
- in_ready, en_out, val_out, data_out, count and overflow all depend only on registered state.

## Test plan
- Reset then idle:
  - Hold reset for 2 cycles.
  - Required: en_out=0, val_out=0, count=0, in_ready=1, overflow=0, index_out=PORT_ID.
- Single flit:
  - Push time=5, data=0xA5 at cycle 1.
  - Required at cycle 2: en_out=1, val_out=5, data_out=0xA5.
  - Then apply win_valid=1, win_index=PORT_ID. Required next cycle: en_out=0, count=0.
- Fill and overflow, DEPTH=4:
  - Push times 10, 11, 12, 13. Required: count=4, in_ready=0.
  - Push time 14. Required: overflow=1, count stays 4.
  - Pop 4 times. Required: heads of 10, 11, 12, 13 in order; time 14 never appears.
- Simultaneous push/pop with wrap:
  - Keep count=2 while pushing and granting every cycle for 10 cycles, with times 0 to 9.
  - Required: count stays 2; output heads run 0 to 7 in order across pointer wrap.
- Foreign and idle grants:
  - Apply win_valid=1 with win_index=PORT_ID+1 while non-empty. Required: no pop.
  - Apply win_valid=1 with win_index=PORT_ID while empty. Required: count stays 0.
- Reset mid-operation:
  - With count=3, assert reset together with a push and a grant.
  - Required next cycle: count=0, en_out=0, overflow=0.

Source files
------------

// File: rtl/age_port_buffer.sv
// Per-input-port flit FIFO feeding an age arbiter leaf: holds {timestamp, payload}
// entries and presents the head to the arbiter, dequeuing when the grant names this port.
`ifndef TIME_WIDTH
`define TIME_WIDTH 16
`endif

module age_port_buffer #(
    parameter int DEPTH       = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int WIDTH_INDEX = 3,
    parameter int PORT_ID     = 0
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [`TIME_WIDTH-1:0]       in_time,
    input  logic [DATA_WIDTH-1:0]        in_data,
    output logic                         in_ready,
    output logic                         en_out,
    output logic [`TIME_WIDTH-1:0]       val_out,
    output logic [WIDTH_INDEX-1:0]       index_out,
    output logic [DATA_WIDTH-1:0]        data_out,
    input  logic                         win_valid,
    input  logic [WIDTH_INDEX-1:0]       win_index,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         overflow
);

    localparam int TW    = `TIME_WIDTH;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]       DEPTH_C = CNT_W'(DEPTH);
    localparam logic [WIDTH_INDEX-1:0] MY_ID   = WIDTH_INDEX'(PORT_ID);

    // Handshake: a flit transfers on a cycle where in_valid and in_ready are both
    // high at the rising edge; in_ready comes from registered occupancy only, so a
    // pop in the same cycle never frees a slot for a push into a full buffer.

    logic [TW-1:0]         time_mem [DEPTH];
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;

    logic push;
    logic pop;
    logic grant_hit;

    assign in_ready  = (count_q < DEPTH_C);
    assign en_out    = (count_q != '0);
    assign grant_hit = win_valid & (win_index == MY_ID);

    assign push = in_valid & in_ready;
    assign pop  = grant_hit & en_out;

    // Control state: pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (in_valid & ~in_ready) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // Storage is not reset; en_out gates visibility of stale entries.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            time_mem[wr_ptr] <= in_time;
            data_mem[wr_ptr] <= in_data;
        end
    end

    always_comb begin
        val_out  = '0;
        data_out = '0;
        if (en_out) begin
            val_out  = time_mem[rd_ptr];
            data_out = data_mem[rd_ptr];
        end
    end

    assign index_out = MY_ID;
    assign count     = count_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_age_port_buffer.sv
// Bench for age_port_buffer: directed scenarios plus random traffic, checked
// cycle by cycle against a queue-based reference model.
`ifndef TIME_WIDTH
`define TIME_WIDTH 16
`endif

module tb_age_port_buffer;

    localparam int DEPTH   = 4;
    localparam int DW      = 32;
    localparam int WI      = 3;
    localparam int PORT_ID = 2;
    localparam int TW      = `TIME_WIDTH;
    localparam int W       = TW + DW;
    localparam int CW      = $clog2(DEPTH) + 1;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic [TW-1:0] in_time;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          en_out;
    logic [TW-1:0] val_out;
    logic [WI-1:0] index_out;
    logic [DW-1:0] data_out;
    logic          win_valid;
    logic [WI-1:0] win_index;
    logic [CW-1:0] count;
    logic          overflow;

    age_port_buffer #(
        .DEPTH(DEPTH), .DATA_WIDTH(DW), .WIDTH_INDEX(WI), .PORT_ID(PORT_ID)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_time(in_time), .in_data(in_data), .in_ready(in_ready),
        .en_out(en_out), .val_out(val_out), .index_out(index_out), .data_out(data_out),
        .win_valid(win_valid), .win_index(win_index),
        .count(count), .overflow(overflow)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    // scoreboard: reference FIFO of {time, data}
    logic [W-1:0] exp_q[$];
    logic         exp_ovf;
    int           n_checks;
    int           n_errors;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs();
        logic [W-1:0] head;
        head = (exp_q.size() != 0) ? exp_q[0] : '0;
        check("en_out",    64'(en_out),    64'(exp_q.size() != 0));
        check("val_out",   64'(val_out),   64'(head[W-1:DW]));
        check("data_out",  64'(data_out),  64'(head[DW-1:0]));
        check("count",     64'(count),     64'(exp_q.size()));
        check("in_ready",  64'(in_ready),  64'(exp_q.size() < DEPTH));
        check("overflow",  64'(overflow),  64'(exp_ovf));
        check("index_out", 64'(index_out), 64'(PORT_ID));
    endtask

    // driver: apply one cycle of inputs, advance the model, check after the edge
    task automatic drive_cycle(input logic rst, input logic iv, input logic [TW-1:0] it,
                               input logic [DW-1:0] id, input logic wv, input logic [WI-1:0] wi);
        bit do_push;
        bit do_pop;
        @(negedge clk);
        reset     = rst;
        in_valid  = iv;
        in_time   = it;
        in_data   = id;
        win_valid = wv;
        win_index = wi;
        if (rst) begin
            exp_q.delete();
            exp_ovf = 1'b0;
        end else begin
            do_pop  = wv && (exp_q.size() != 0) && (wi == WI'(PORT_ID));
            do_push = iv && (exp_q.size() < DEPTH);
            if (iv && !do_push) exp_ovf = 1'b1;
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) exp_q.push_back({it, id});
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic idle();
        drive_cycle(1'b0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic push_only(input logic [TW-1:0] t, input logic [DW-1:0] d);
        drive_cycle(1'b0, 1'b1, t, d, 1'b0, '0);
    endtask

    task automatic grant_only(input logic [WI-1:0] wi);
        drive_cycle(1'b0, 1'b0, '0, '0, 1'b1, wi);
    endtask

    task automatic do_reset();
        drive_cycle(1'b1, 1'b0, '0, '0, 1'b0, '0);
        drive_cycle(1'b1, 1'b0, '0, '0, 1'b0, '0);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        exp_ovf   = 1'b0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_time   = '0;
        in_data   = '0;
        win_valid = 1'b0;
        win_index = '0;

        // reset then idle
        do_reset();
        idle();

        // single flit, then grant
        push_only(TW'(5), DW'(32'hA5));
        check("single_head_time", 64'(val_out), 64'd5);
        check("single_head_data", 64'(data_out), 64'hA5);
        grant_only(WI'(PORT_ID));
        check("single_drained", 64'(count), 64'd0);

        // fill, overflow, drain in order
        for (int i = 0; i < 4; i++) push_only(TW'(10 + i), DW'(32'h100 + i));
        check("full_count", 64'(count), 64'd4);
        check("full_ready", 64'(in_ready), 64'd0);
        push_only(TW'(14), DW'(32'h104));
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_count", 64'(count), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check("drain_head", 64'(val_out), 64'(10 + i));
            grant_only(WI'(PORT_ID));
        end
        check("drain_empty", 64'(en_out), 64'd0);

        // simultaneous push/pop across pointer wrap, occupancy held at 2
        do_reset();
        push_only(TW'(0), DW'(32'h200));
        push_only(TW'(1), DW'(32'h201));
        for (int i = 2; i < 10; i++) begin
            check("wrap_head", 64'(val_out), 64'(i - 2));
            drive_cycle(1'b0, 1'b1, TW'(i), DW'(32'h200 + i), 1'b1, WI'(PORT_ID));
            check("wrap_count", 64'(count), 64'd2);
        end

        // foreign grant while non-empty, own grant while empty
        grant_only(WI'(PORT_ID + 1));
        check("foreign_no_pop", 64'(count), 64'd2);
        grant_only(WI'(PORT_ID));
        grant_only(WI'(PORT_ID));
        grant_only(WI'(PORT_ID));
        check("empty_grant", 64'(count), 64'd0);

        // reset mid-operation with push and grant coinciding
        for (int i = 0; i < 3; i++) push_only(TW'(30 + i), DW'(32'h300 + i));
        push_only(TW'(33), DW'(32'h303));
        push_only(TW'(34), DW'(32'h304));
        check("pre_reset_ovf", 64'(overflow), 64'd1);
        grant_only(WI'(PORT_ID));
        check("pre_reset_count", 64'(count), 64'd3);
        drive_cycle(1'b1, 1'b1, TW'(40), DW'(32'h400), 1'b1, WI'(PORT_ID));
        check("midreset_count", 64'(count), 64'd0);
        check("midreset_en", 64'(en_out), 64'd0);
        check("midreset_ovf", 64'(overflow), 64'd0);

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            logic          r;
            logic          iv;
            logic          wv;
            logic [WI-1:0] wi;
            r  = ($urandom_range(0, 199) == 0);
            iv = ($urandom_range(0, 99) < 55);
            wv = ($urandom_range(0, 99) < 50);
            wi = ($urandom_range(0, 3) != 0) ? WI'(PORT_ID) : WI'($urandom_range(0, (1 << WI) - 1));
            drive_cycle(r, iv, TW'($urandom), DW'($urandom), wv, wi);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
